// File: rtl/conv3x3_psum_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | conv3x3_psum_ctrl: sequencer and channel accumulator for the pipelined |
// | 3x3 partial-sum adder tree.                       Revision 1.0         |
// +------------------------------------------------------------------------+
module conv3x3_psum_ctrl #(
  parameter int CH_W  = 8,
  parameter int PIX_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [CH_W-1:0]  cfg_ch_num,
  input  logic [PIX_W-1:0] cfg_pix_num,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tree_pipe_en,
  input  logic [31:0]      tree_psum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CH_W-1:0]  ch_num, in_ch_cnt, acc_ch_cnt;
  logic [PIX_W-1:0] pix_num, in_pix_cnt, out_pix_cnt;
  logic             v1, v2;
  logic [31:0]      acc, acc_next;
  logic             start, accept, acc_fire, in_ch_last, acc_ch_last;
  logic             last_in, out_hs, last_out;

  // One stall signal freezes the whole tree, the valid shadow and the accumulator.
  assign tree_pipe_en = !(out_valid && !out_ready);
  assign in_ready     = (state == S_RUN) && tree_pipe_en;
  assign accept       = in_valid && in_ready;
  assign start        = (state == S_IDLE) && cfg_start;

  assign in_ch_last   = (in_ch_cnt == ch_num - CH_W'(1));
  assign last_in      = accept && in_ch_last && (in_pix_cnt == pix_num - PIX_W'(1));
  assign acc_fire     = v2 && tree_pipe_en;
  assign acc_ch_last  = (acc_ch_cnt == ch_num - CH_W'(1));
  assign acc_next     = ((acc_ch_cnt == '0) ? 32'd0 : acc) + tree_psum;
  assign out_hs       = out_valid && out_ready;
  assign last_out     = out_hs && (out_pix_cnt == pix_num);

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cfg_start) state_nxt = S_RUN;
      S_RUN:   if (last_in)   state_nxt = S_DRAIN;
      S_DRAIN: if (last_out)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_num      <= '0;
      pix_num     <= '0;
      in_ch_cnt   <= '0;
      in_pix_cnt  <= '0;
      acc_ch_cnt  <= '0;
      out_pix_cnt <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      acc         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
    end else if (start) begin
      ch_num      <= (cfg_ch_num == '0)  ? CH_W'(1)  : cfg_ch_num;
      pix_num     <= (cfg_pix_num == '0) ? PIX_W'(1) : cfg_pix_num;
      in_ch_cnt   <= '0;
      in_pix_cnt  <= '0;
      acc_ch_cnt  <= '0;
      out_pix_cnt <= '0;
      acc         <= '0;
      if (tree_pipe_en) begin
        v1 <= 1'b0;
        v2 <= v1;
      end
    end else begin
      if (tree_pipe_en) begin
        v1 <= accept;
        v2 <= v1;
      end

      if (accept) begin
        if (in_ch_last) begin
          in_ch_cnt  <= '0;
          in_pix_cnt <= in_pix_cnt + PIX_W'(1);
        end else begin
          in_ch_cnt  <= in_ch_cnt + CH_W'(1);
        end
      end

      if (acc_fire) begin
        acc <= acc_next;
        if (acc_ch_last) begin
          acc_ch_cnt  <= '0;
          out_data    <= acc_next;
          out_pix_cnt <= out_pix_cnt + PIX_W'(1);
        end else begin
          acc_ch_cnt  <= acc_ch_cnt + CH_W'(1);
        end
      end

      // A fresh capture on the handshake edge keeps out_valid high.
      if (acc_fire && acc_ch_last) out_valid <= 1'b1;
      else if (out_hs)             out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_psum_ctrl.sv
`default_nettype none
// Scoreboard bench for conv3x3_psum_ctrl with a two-stage tree model in front.
module tb_conv3x3_psum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  cfg_ch_num = '0;
  logic [11:0] cfg_pix_num = '0;
  logic        busy, done;
  logic        in_valid = 1'b0;
  logic        in_ready, tree_pipe_en;
  logic [31:0] tree_psum;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [31:0] in_data = '0;
  logic [31:0] st1 = '0, st2 = '0;

  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  logic [31:0] exp_q[$];

  conv3x3_psum_ctrl #(.CH_W(8), .PIX_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_ch_num(cfg_ch_num),
    .cfg_pix_num(cfg_pix_num), .busy(busy), .done(done), .in_valid(in_valid),
    .in_ready(in_ready), .tree_pipe_en(tree_pipe_en), .tree_psum(tree_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tree model: the product vector sum enters stage 1, stage 2 feeds tree_psum.
  always @(posedge clk) if (tree_pipe_en) begin
    st1 <= in_data;
    st2 <= st1;
  end
  assign tree_psum = st2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_extra: got %0h expected none", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic start_job(input logic [7:0] ch, input logic [11:0] pix);
    cfg_ch_num  = ch;
    cfg_pix_num = pix;
    cfg_start   = 1'b1;
    @(posedge clk); #1;
    cfg_start   = 1'b0;
  endtask

  task automatic drive(input logic [31:0] v);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("accept");
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) timeout("done");
    else begin
      check("busy_in_done", busy, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_pipe_en"}, tree_pipe_en, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, first;
    logic [31:0] job2 [6];
    job2 = '{32'd10, 32'd20, 32'd30, 32'd1, 32'd2, 32'd3};

    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Single channel, single pixel: latency and done pulse.
    check("idle_busy", busy, 0);
    start_job(8'd1, 12'd1);
    check("busy_after_start", busy, 1);
    exp_q.push_back(32'd100);
    drive(32'd100);
    k = acc_cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", cyc - k, 3);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_cycle", cyc - k, 4);
    check("busy_low_done", busy, 0);
    @(negedge clk);
    check("done_clear", done, 0);

    // Three channels, two pixels, full throughput.
    start_job(8'd3, 12'd2);
    exp_q.push_back(32'd60);
    exp_q.push_back(32'd6);
    first = 0;
    for (int i = 0; i < 6; i++) begin
      drive(job2[i]);
      if (i == 0) first = acc_cyc;
    end
    check("no_bubbles", acc_cyc - first, 5);
    wait_done();

    // Same job with a five-cycle stall on the first result.
    out_ready = 1'b0;
    start_job(8'd3, 12'd2);
    exp_q.push_back(32'd60);
    exp_q.push_back(32'd6);
    fork
      begin
        for (int i = 0; i < 6; i++) drive(job2[i]);
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (out_valid) begin seen = 1; break; end
        end
        if (!seen) timeout("first_result");
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("stall_pipe_en", tree_pipe_en, 0);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_data", out_data, 32'd60);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_done();

    // Modulo-2^32 wrap.
    start_job(8'd2, 12'd1);
    exp_q.push_back(32'd1);
    drive(32'hFFFF_FFFF);
    drive(32'd2);
    wait_done();

    // Zero configs behave as one channel, one pixel.
    start_job(8'd0, 12'd0);
    exp_q.push_back(32'd5);
    drive(32'd5);
    wait_done();

    // Start pulse during a job is ignored.
    start_job(8'd2, 12'd1);
    exp_q.push_back(32'd9);
    drive(32'd4);
    cfg_ch_num  = 8'd1;
    cfg_pix_num = 12'd3;
    cfg_start   = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    drive(32'd5);
    wait_done();

    // Reset after two of three channels, then a fresh job.
    start_job(8'd3, 12'd1);
    drive(32'd50);
    drive(32'd60);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    start_job(8'd1, 12'd1);
    exp_q.push_back(32'd7);
    drive(32'd7);
    wait_done();

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
